// File: rtl/dice_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dice_pkg
// Description : Shared types, die bounds and roll-count saturation helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] DIE_MIN = 3'd1;
  localparam logic [2:0] DIE_MAX = 3'd6;

  // A request for zero rolls still rolls once; oversize requests clamp.
  function automatic int unsigned sat_count(input int unsigned count,
                                            input int unsigned max_cnt);
    if (count == 0) return 1;
    if (count > max_cnt) return max_cnt;
    return count;
  endfunction

endpackage
`default_nettype wire

// File: rtl/die_counter_1to6.sv
`default_nettype none
// ============================================================================
// Module      : die_counter_1to6
// Description : Free-running die face counter cycling 1..6 every clock.
// Revision    : 1.0 - initial release
// ============================================================================
module die_counter_1to6
  import dice_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  output logic [2:0] o_die
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_die <= DIE_MIN;
    end else if (o_die == DIE_MAX) begin
      o_die <= DIE_MIN;
    end else begin
      o_die <= o_die + 3'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dice_roll_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dice_roll_scheduler
// Description : Round-robin shares one die among requesters, returns roll sums.
// Revision    : 1.0 - initial release
// ============================================================================
module dice_roll_scheduler
  import dice_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int MAX_DICE = 6,
  localparam int CNT_W    = $clog2(MAX_DICE + 1),
  localparam int SUM_W    = $clog2(6 * MAX_DICE + 1),
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*CNT_W-1:0] req_count,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [SUM_W-1:0]       rsp_sum,
  input  logic                   rsp_ready,
  output logic                   busy
);

  state_t           r_state;
  logic [ID_W-1:0]  r_id;
  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] r_acc;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [2:0]       w_die;
  logic [ID_W:0]    w_pick;
  logic [ID_W-1:0]  w_gid;
  logic [CNT_W-1:0] w_cnt_arr [N_REQ];

  die_counter_1to6 u_die (
    .clk   (clk),
    .rstn  (rstn),
    .o_die (w_die)
  );

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign w_cnt_arr[i] = req_count[i*CNT_W +: CNT_W];
  end

  // Returns {found, id}; lowest k after the pointer wins, so the last write is kept.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] vld,
                                            input logic [ID_W-1:0]  ptr);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (vld[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_pick = rr_pick(req_valid, r_rr_ptr);
  assign w_gid  = w_pick[ID_W-1:0];

  always_comb begin
    req_ready = '0;
    if (r_state == IDLE && w_pick[ID_W]) req_ready[w_gid] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_id     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_rr_ptr <= ID_W'(N_REQ - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick[ID_W]) begin
            r_id     <= w_gid;
            r_cnt    <= CNT_W'(sat_count(32'(w_cnt_arr[w_gid]), MAX_DICE));
            r_acc    <= '0;
            r_rr_ptr <= w_gid;
            r_state  <= ROLL;
          end
        end
        ROLL: begin
          r_acc <= r_acc + SUM_W'(w_die);
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= RESP;
        end
        RESP: begin
          if (rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign rsp_id    = r_id;
  assign rsp_sum   = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_dice_roll_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dice_roll_scheduler
// Description : Scoreboard bench for dice_roll_scheduler with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dice_roll_scheduler;

  localparam int N_REQ    = 4;
  localparam int MAX_DICE = 6;
  localparam int CNT_W    = 3;
  localparam int SUM_W    = 6;
  localparam int ID_W     = 2;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ*CNT_W-1:0] req_count = '0;
  logic [N_REQ-1:0]       req_ready;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic [SUM_W-1:0]       rsp_sum;
  logic                   rsp_ready = 1'b1;
  logic                   busy;

  always #5 clk = ~clk;

  dice_roll_scheduler #(.N_REQ(N_REQ), .MAX_DICE(MAX_DICE)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_count (req_count),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  typedef struct { int id; bit b2b; } gnt_t;
  typedef struct { int id; int sum; int n; int due; } rsp_t;

  gnt_t exp_gnt[$];
  rsp_t exp_rsp[$];
  rsp_t cur_rsp;
  int   errors = 0, checks = 0;
  int   cyc = 0, since_rst = 0, n_grants = 0, acc_cyc = -100;
  bit   in_rsp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rstn)
    if (!rstn) since_rst <= 0;
    else       since_rst <= since_rst + 1;

  // Monitor: checks grants against the expected order and responses against the model.
  always @(negedge clk) begin : mon
    int   gid, cnt, n, sum;
    gnt_t g;
    if (!rstn) begin
      in_rsp = 0;
    end else begin
      chk("die_value", 32'(dut.w_die), (since_rst % 6) + 1);
      if (req_ready != '0) begin
        gid = 0;
        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) gid = i;
        chk("grant_onehot", $countones(req_ready), 1);
        chk("grant_when_idle", 32'(busy), 0);
        if (exp_gnt.size() == 0) begin
          fail("unexpected_grant");
        end else begin
          g = exp_gnt.pop_front();
          chk("grant_id", gid, g.id);
          if (g.b2b) chk("grant_after_accept", cyc, acc_cyc + 1);
          cnt = int'(req_count[g.id*CNT_W +: CNT_W]);
          n   = (cnt == 0) ? 1 : ((cnt > MAX_DICE) ? MAX_DICE : cnt);
          sum = 0;
          for (int k = 1; k <= n; k++) sum += ((since_rst + k) % 6) + 1;
          exp_rsp.push_back('{g.id, sum, n, cyc + n + 1});
          n_grants++;
        end
      end
      if (rsp_valid) begin
        if (!in_rsp) begin
          if (exp_rsp.size() == 0) begin
            fail("unexpected_response");
          end else begin
            cur_rsp = exp_rsp.pop_front();
            in_rsp  = 1;
            chk("rsp_latency", cyc, cur_rsp.due);
            chk("rsp_busy", 32'(busy), 1);
            chk("rsp_sum_range", 32'(rsp_sum >= cur_rsp.n && rsp_sum <= 6 * cur_rsp.n), 1);
            if (cur_rsp.n == 6) chk("rsp_sum_six_rolls", 32'(rsp_sum), 21);
          end
        end
        if (in_rsp) begin
          chk("rsp_id", 32'(rsp_id), cur_rsp.id);
          chk("rsp_sum", 32'(rsp_sum), cur_rsp.sum);
          if (rsp_ready) begin
            in_rsp  = 0;
            acc_cyc = cyc;
          end
        end
      end else if (in_rsp) begin
        fail("rsp_dropped_before_accept");
        in_rsp = 0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int id, input int cnt, input bit b2b);
    req_count[id*CNT_W +: CNT_W] = CNT_W'(cnt);
    req_valid[id] = 1'b1;
    exp_gnt.push_back('{id, b2b});
  endtask

  task automatic wait_grant_drop(input int id);
    int t;
    for (t = 0; t < 300; t++) begin
      @(negedge clk);
      if (req_ready[id]) break;
    end
    if (t == 300) fail("grant_timeout");
    tick();
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int t;
    for (t = 0; t < 300; t++) begin
      tick();
      if (exp_gnt.size() == 0 && exp_rsp.size() == 0 && !in_rsp && !busy) break;
    end
    if (t == 300) fail("drain_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_id"},    32'(rsp_id), 0);
    chk({tag, "_rsp_sum"},   32'(rsp_sum), 0);
    chk({tag, "_busy"},      32'(busy), 0);
    chk({tag, "_die"},       32'(dut.w_die), 1);
  endtask

  initial begin
    int t;
    #12;
    check_reset_outputs("reset");
    tick();
    rstn = 1'b1;

    // Six rolls from requester 0: latency 7, sum 21.
    set_req(0, 6, 0);
    wait_grant_drop(0);
    drain();

    // Single roll from requester 2.
    set_req(2, 1, 0);
    wait_grant_drop(2);
    drain();

    // Count 0 from requester 3 rolls once; also leaves requester 3 as last served.
    set_req(3, 0, 0);
    wait_grant_drop(3);
    drain();

    // All four requesting continuously: rotation 0,1,2,3,0.
    for (int i = 0; i < N_REQ; i++) req_count[i*CNT_W +: CNT_W] = 3'd2;
    exp_gnt.push_back('{0, 0});
    exp_gnt.push_back('{1, 1});
    exp_gnt.push_back('{2, 1});
    exp_gnt.push_back('{3, 1});
    exp_gnt.push_back('{0, 1});
    t = n_grants;
    req_valid = '1;
    for (int k = 0; k < 300 && n_grants < t + 5; k++) tick();
    if (n_grants < t + 5) fail("rotation_timeout");
    req_valid = '0;
    drain();

    // Count 7 saturates to six rolls.
    set_req(0, 7, 0);
    wait_grant_drop(0);
    drain();

    // Backpressure: response held for 10 cycles with another request pending.
    rsp_ready = 1'b0;
    set_req(1, 3, 0);
    wait_grant_drop(1);
    set_req(2, 2, 1);
    for (t = 0; t < 50 && !rsp_valid; t++) tick();
    if (!rsp_valid) fail("rsp_wait_timeout");
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("ready_blocked_in_resp", 32'(req_ready), 0);
      chk("valid_held", 32'(rsp_valid), 1);
    end
    rsp_ready = 1'b1;
    wait_grant_drop(2);
    drain();

    // Reset during ROLL discards the in-flight request.
    set_req(0, 6, 0);
    wait_grant_drop(0);
    tick(2);
    rstn = 1'b0;
    exp_gnt.delete();
    exp_rsp.delete();
    #1;
    check_reset_outputs("midroll_reset");
    tick(2);
    rstn = 1'b1;
    req_count[1*CNT_W +: CNT_W] = 3'd1;
    req_count[3*CNT_W +: CNT_W] = 3'd2;
    exp_gnt.push_back('{1, 0});
    exp_gnt.push_back('{3, 1});
    req_valid = 4'b1010;
    wait_grant_drop(1);
    wait_grant_drop(3);
    drain();
    tick(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
